// File: rtl/apb_arbiter.sv
// Two-requester APB master with round-robin arbitration and a wait-state timeout.
// Every output is a register; the FSM next-state logic computes each register's next value.
module apb_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              prstn,
    input  logic              req0,
    input  logic              req1,
    input  logic              write0,
    input  logic              write1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    output logic              pwrite,
    output logic              psel,
    output logic              penable,
    input  logic              pready,
    input  logic              pslverr,
    input  logic [DATA_W-1:0] prdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    state_t            state, state_n;
    logic              prio, prio_n;
    logic [7:0]        cnt, cnt_n;
    logic [ADDR_W-1:0] paddr_n;
    logic [DATA_W-1:0] pwdata_n, rdata_n;
    logic              pwrite_n, psel_n, penable_n;
    logic              gnt0_n, gnt1_n, done0_n, done1_n, err_n;
    logic              el0, el1, pick1;

    // A requester whose done is still high is finishing its handshake.
    assign el0   = req0 & ~done0;
    assign el1   = req1 & ~done1;
    assign pick1 = el1 & (~el0 | prio);

    always_comb begin
        state_n   = state;
        prio_n    = prio;
        cnt_n     = cnt;
        paddr_n   = paddr;
        pwdata_n  = pwdata;
        pwrite_n  = pwrite;
        psel_n    = psel;
        penable_n = penable;
        gnt0_n    = gnt0;
        gnt1_n    = gnt1;
        done0_n   = 1'b0;
        done1_n   = 1'b0;
        rdata_n   = rdata;
        err_n     = err;
        unique case (state)
            IDLE: begin
                if (el0 | el1) begin
                    state_n   = SETUP;
                    prio_n    = ~pick1;
                    psel_n    = 1'b1;
                    penable_n = 1'b0;
                    gnt0_n    = ~pick1;
                    gnt1_n    = pick1;
                    paddr_n   = pick1 ? addr1 : addr0;
                    pwrite_n  = pick1 ? write1 : write0;
                    if (pick1)
                        pwdata_n = write1 ? wdata1 : '0;
                    else
                        pwdata_n = write0 ? wdata0 : '0;
                end
            end
            SETUP: begin
                state_n   = ACCESS;
                penable_n = 1'b1;
                cnt_n     = '0;
            end
            ACCESS: begin
                if (pready || cnt == LAST) begin
                    state_n   = IDLE;
                    psel_n    = 1'b0;
                    penable_n = 1'b0;
                    gnt0_n    = 1'b0;
                    gnt1_n    = 1'b0;
                    done0_n   = gnt0;
                    done1_n   = gnt1;
                    err_n     = pready ? pslverr : 1'b1;
                    if (pready && !pwrite)
                        rdata_n = prdata;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            state   <= IDLE;
            prio    <= 1'b0;
            cnt     <= '0;
            paddr   <= '0;
            pwdata  <= '0;
            pwrite  <= 1'b0;
            psel    <= 1'b0;
            penable <= 1'b0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            done0   <= 1'b0;
            done1   <= 1'b0;
            rdata   <= '0;
            err     <= 1'b0;
        end else begin
            state   <= state_n;
            prio    <= prio_n;
            cnt     <= cnt_n;
            paddr   <= paddr_n;
            pwdata  <= pwdata_n;
            pwrite  <= pwrite_n;
            psel    <= psel_n;
            penable <= penable_n;
            gnt0    <= gnt0_n;
            gnt1    <= gnt1_n;
            done0   <= done0_n;
            done1   <= done1_n;
            rdata   <= rdata_n;
            err     <= err_n;
        end
    end

endmodule

// File: tb/tb_apb_arbiter.sv
// Directed self-checking bench for apb_arbiter (TIMEOUT=4).
// Each task drives one scenario and checks hand-computed values inline.
module tb_apb_arbiter;

    logic       pclk = 1'b0;
    logic       prstn = 1'b0;
    logic       req0 = 0, req1 = 0, write0 = 0, write1 = 0;
    logic [7:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
    logic       gnt0, gnt1, done0, done1, err;
    logic [7:0] rdata, paddr, pwdata, prdata = 0;
    logic       pwrite, psel, penable;
    logic       pready = 0, pslverr = 0;
    int         checks = 0;
    int         errors = 0;

    apb_arbiter #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(4)) dut (
        .pclk(pclk), .prstn(prstn),
        .req0(req0), .req1(req1),
        .write0(write0), .write1(write1),
        .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1),
        .done0(done0), .done1(done1),
        .rdata(rdata), .err(err),
        .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
        .psel(psel), .penable(penable),
        .pready(pready), .pslverr(pslverr), .prdata(prdata)
    );

    always #5 pclk = ~pclk;

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic do_reset();
        prstn = 1'b0;
        req0 = 0; req1 = 0;
        step();
        prstn = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] got;
        prstn = 1'b0;
        step();
        got = {paddr, pwdata, rdata, pwrite, psel, penable, gnt0, gnt1, done0, done1, err};
        checks++;
        if (got !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0", got);
        end
        step();
        checks++;
        if (psel !== 1'b0 || gnt0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold psel %b gnt0 %b exp 0 0", psel, gnt0);
        end
        prstn = 1'b1;
    endtask

    task automatic test_single_write();
        req0 = 1; write0 = 1; addr0 = 8'h12; wdata0 = 8'hA5; pready = 1;
        step();
        checks++;
        if ({psel, penable, pwrite, gnt0, gnt1, done0} !== 6'b101100 ||
            paddr !== 8'h12 || pwdata !== 8'hA5) begin
            errors++;
            $display("FAIL wr_setup sel/en/wr/g0/g1/d0 %b addr %h data %h exp 101100 12 A5",
                     {psel, penable, pwrite, gnt0, gnt1, done0}, paddr, pwdata);
        end
        step();
        checks++;
        if ({psel, penable, gnt0, done0} !== 4'b1110 || paddr !== 8'h12) begin
            errors++;
            $display("FAIL wr_access sel/en/g0/d0 %b addr %h exp 1110 12",
                     {psel, penable, gnt0, done0}, paddr);
        end
        step();
        checks++;
        if ({psel, penable, gnt0, done0, done1, err} !== 6'b000100) begin
            errors++;
            $display("FAIL wr_done sel/en/g0/d0/d1/err %b exp 000100",
                     {psel, penable, gnt0, done0, done1, err});
        end
        req0 = 0;
        step();
        checks++;
        if ({done0, psel} !== 2'b00) begin
            errors++;
            $display("FAIL wr_pulse done0/psel %b exp 00", {done0, psel});
        end
    endtask

    task automatic test_contention();
        logic [3:0] exp, got;
        do_reset();
        req0 = 1; req1 = 1; write0 = 1; write1 = 1;
        addr0 = 8'h01; addr1 = 8'h02; wdata0 = 8'h11; wdata1 = 8'h22; pready = 1;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 3; j++) begin
                step();
                exp = {(j < 2) && (k % 2 == 0), (j < 2) && (k % 2 == 1),
                       (j == 2) && (k % 2 == 0), (j == 2) && (k % 2 == 1)};
                got = {gnt0, gnt1, done0, done1};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL rr_k%0d_j%0d g0/g1/d0/d1 %b exp %b", k, j, got, exp);
                end
                if (j == 0) begin
                    checks++;
                    if (paddr !== ((k % 2 == 0) ? 8'h01 : 8'h02)) begin
                        errors++;
                        $display("FAIL rr_addr_k%0d got %h", k, paddr);
                    end
                end
            end
        end
        req0 = 0; req1 = 0;
        step();
    endtask

    task automatic test_wait_read();
        req1 = 1; write1 = 0; addr1 = 8'h40; wdata1 = 8'hFF; pready = 0; prdata = 8'h00;
        step();
        checks++;
        if ({psel, penable, pwrite, gnt1} !== 4'b1001 || paddr !== 8'h40 || pwdata !== 8'h00) begin
            errors++;
            $display("FAIL rd_setup sel/en/wr/g1 %b addr %h data %h exp 1001 40 00",
                     {psel, penable, pwrite, gnt1}, paddr, pwdata);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({psel, penable, gnt1, done1} !== 4'b1110 || paddr !== 8'h40 || pwrite !== 1'b0) begin
                errors++;
                $display("FAIL rd_wait%0d sel/en/g1/d1 %b addr %h exp 1110 40",
                         i, {psel, penable, gnt1, done1}, paddr);
            end
        end
        pready = 1; prdata = 8'h3C;
        step();
        checks++;
        if ({done1, err, psel} !== 3'b100 || rdata !== 8'h3C) begin
            errors++;
            $display("FAIL rd_done d1/err/sel %b rdata %h exp 100 3C", {done1, err, psel}, rdata);
        end
        req1 = 0; prdata = 8'h77;
        step();
    endtask

    task automatic test_timeout();
        req0 = 1; write0 = 0; addr0 = 8'h55; pready = 0;
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({psel, penable, done0} !== 3'b110) begin
                errors++;
                $display("FAIL to_access%0d sel/en/d0 %b exp 110", i, {psel, penable, done0});
            end
        end
        step();
        checks++;
        if ({done0, err, psel, penable, gnt0} !== 5'b11000 || rdata !== 8'h3C) begin
            errors++;
            $display("FAIL to_abort d0/err/sel/en/g0 %b rdata %h exp 11000 3C",
                     {done0, err, psel, penable, gnt0}, rdata);
        end
        req0 = 0;
        step();
    endtask

    task automatic test_slverr();
        req0 = 1; write0 = 1; addr0 = 8'h20; wdata0 = 8'h5A; pready = 1; pslverr = 1;
        step();
        step();
        step();
        checks++;
        if ({done0, err} !== 2'b11 || rdata !== 8'h3C) begin
            errors++;
            $display("FAIL slverr d0/err %b rdata %h exp 11 3C", {done0, err}, rdata);
        end
        req0 = 0; pslverr = 0;
        step();
    endtask

    task automatic test_reset_mid();
        req0 = 1; req1 = 1; write0 = 0; write1 = 0; pready = 0;
        step();
        step();
        checks++;
        if ({psel, penable, gnt0 | gnt1} !== 3'b111) begin
            errors++;
            $display("FAIL mid_access sel/en/gnt %b exp 111", {psel, penable, gnt0 | gnt1});
        end
        #2 prstn = 1'b0;
        #1;
        checks++;
        if ({psel, penable, gnt0, gnt1, done0, done1} !== 6'b0) begin
            errors++;
            $display("FAIL mid_async sel/en/g0/g1/d0/d1 %b exp 000000",
                     {psel, penable, gnt0, gnt1, done0, done1});
        end
        step();
        checks++;
        if ({done0, done1, psel} !== 3'b000) begin
            errors++;
            $display("FAIL mid_nodone d0/d1/sel %b exp 000", {done0, done1, psel});
        end
        prstn = 1'b1;
        #3;
        checks++;
        if ({gnt0, gnt1} !== 2'b00) begin
            errors++;
            $display("FAIL mid_early g0/g1 %b exp 00", {gnt0, gnt1});
        end
        step();
        checks++;
        if ({gnt0, gnt1, psel} !== 3'b101) begin
            errors++;
            $display("FAIL mid_tie g0/g1/sel %b exp 101", {gnt0, gnt1, psel});
        end
        req0 = 0; req1 = 0; pready = 1;
        step();
        step();
        step();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_contention();
        test_wait_read();
        test_timeout();
        test_slverr();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_arbiter.md
APB_ARBITER -- requirements
Module: apb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, address width.
REQ-002 SHALL have parameter DATA_W, default 8, data width.
REQ-003 SHALL have parameter TIMEOUT, default 16, range 2..255; maximum ACCESS cycles with pready low before abort.
REQ-004 SHALL have port pclk  input  1  bus clock; all logic on rising edge.
REQ-005 SHALL have port prstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports req0, req1  input  1  transfer request per requester, held until its done pulse.
REQ-007 SHALL have ports write0, write1  input  1  direction per requester; 1 = write.
REQ-008 SHALL have ports addr0, addr1  input  ADDR_W  target address per requester.
REQ-009 SHALL have ports wdata0, wdata1  input  DATA_W  write data per requester.
REQ-010 SHALL have ports gnt0, gnt1  output  1  requester owns the bus.
REQ-011 SHALL have ports done0, done1  output  1  one-cycle completion pulse per requester.
REQ-012 SHALL have port rdata  output  DATA_W  read data; valid while any done is high.
REQ-013 SHALL have port err  output  1  completion error (slave error or timeout); valid while any done is high.
REQ-014 SHALL have ports paddr (ADDR_W), pwdata (DATA_W), pwrite, psel, penable  output  APB request signals.
REQ-015 SHALL have ports pready (1), pslverr (1), prdata (DATA_W)  input  APB slave response.

Function
REQ-016 SHALL implement FSM IDLE -> SETUP -> ACCESS -> IDLE; every output SHALL be registered.
REQ-017 In IDLE, a requester with req high and its done low SHALL be eligible; with one eligible requester, that requester SHALL be granted at the next edge.
REQ-018 With both eligible, grant SHALL go to the requester not granted most recently (round-robin); after reset, requester 0 SHALL win the first tie.
REQ-019 On grant, the FSM SHALL enter SETUP.
- paddr and pwrite SHALL load from the winner.
- pwdata SHALL load the winner's wdata if write, else 0.
- psel SHALL be 1, penable 0, and the winner's gnt SHALL be 1.
REQ-020 SETUP SHALL last exactly one cycle, then enter ACCESS with penable=1; paddr, pwdata and pwrite SHALL stay stable through ACCESS.
REQ-021 In ACCESS, on an edge with pready=1:
- FSM SHALL go to IDLE; psel, penable and gnt SHALL clear.
- The owner's done SHALL pulse high for exactly one cycle.
- rdata SHALL capture prdata on reads and hold its previous value on writes.
- err SHALL capture pslverr.
REQ-022 A wait counter SHALL reset on entry to ACCESS and increment on each ACCESS edge with pready=0.
REQ-023 When the counter reaches TIMEOUT-1 and pready is still 0, the FSM SHALL abort to IDLE.
- psel and penable SHALL clear.
- done SHALL pulse with err=1; rdata SHALL be unchanged.
REQ-024 Zero-wait latency: req sampled in IDLE at edge N -> SETUP in cycle N+1, ACCESS in N+2, done high in N+3.
REQ-025 The bus SHALL always return to IDLE for at least one cycle between transfers; back-to-back SETUP is not permitted.
REQ-026 At most one of gnt0/gnt1 and at most one of done0/done1 SHALL be high in any cycle.
REQ-027 Request inputs changing outside IDLE SHALL NOT affect the transfer in progress.

Reset
REQ-028 prstn low SHALL immediately force:
- state to IDLE and the round-robin pointer to favour requester 0;
- paddr, pwdata, pwrite, psel, penable, gnt0/1, done0/1, rdata, err and the wait counter to 0.
REQ-029 Reset asserted mid-transfer SHALL abort the transfer without a done pulse.
REQ-030 After reset release, the first grant SHALL occur no earlier than the first rising edge with prstn high.

Verification
REQ-031 Single write: req0=1, write0=1, addr0=8'h12, wdata0=8'hA5, pready=1 -> SETUP paddr=12 pwdata=A5 psel=1 penable=0; ACCESS penable=1; done0 pulse 3 cycles after sample, err=0.
REQ-032 Contention: req0 and req1 held continuously, pready=1 -> grants alternate 0,1,0,1; each done precedes one IDLE cycle; never two gnt high together.
REQ-033 Wait states and read: req1 read addr 8'h40, pready low 3 ACCESS cycles then high with prdata=8'h3C -> done1 after 3 extra cycles, rdata=3C, signals stable throughout ACCESS.
REQ-034 Timeout: TIMEOUT=4, pready held 0 -> abort after 4 ACCESS cycles, done pulse with err=1, psel=0; pslverr=1 with pready=1 -> err=1.
REQ-035 Reset mid-ACCESS: drop prstn during ACCESS -> psel, penable and gnt clear asynchronously, no done pulse; after release, a tie grants requester 0.
